ldpc_syndrome_counter: RTL

- Streaming, pipelined population counter for LDPC decoder syndrome and hard-decision checks.
- Accepts a DATA_W-bit frame as DATA_W/CHUNK_W beats of CHUNK_W bits over a valid/ready handshake and accumulates the number of set bits.
- Presents the frame weight with zero and below-threshold flags, so the iteration controller can decide early termination.
- Replaces the single-cycle, fixed-width combinational bit counter.

---
 rtl/ldpc_pkg.sv | 25 ++
 rtl/popcount_chunk.sv | 39 +++
 rtl/ldpc_syndrome_counter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ldpc_pkg.sv
// Shared types and constants for the LDPC decoder datapath blocks.
package ldpc_pkg;

  localparam int LDPC_DATA_W  = 2304;
  localparam int LDPC_CHUNK_W = 96;

  typedef logic [3:0] slice_cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational population count of one CHUNK_W-bit word, built from LUT_W-bit slices.
module popcount_chunk
  import ldpc_pkg::*;
#(
  parameter int CHUNK_W = LDPC_CHUNK_W,
  parameter int LUT_W   = 8,
  parameter int OUT_W   = clog2(CHUNK_W + 1)
) (
  input  logic [CHUNK_W-1:0] data_i,
  output logic [OUT_W-1:0]   cnt_o
);

  localparam int N_SLICES = CHUNK_W / LUT_W;

  slice_cnt_t slice_cnt [N_SLICES];

  genvar gi;
  generate
    for (gi = 0; gi < N_SLICES; gi++) begin : g_slice
      slice_cnt_t cnt;
      always_comb begin
        cnt = '0;
        for (int j = 0; j < LUT_W; j++) begin
          cnt = cnt + slice_cnt_t'(data_i[gi*LUT_W + j]);
        end
      end
      assign slice_cnt[gi] = cnt;
    end
  endgenerate

  // Slice sums are small; synthesis balances this chain into an adder tree.
  always_comb begin
    cnt_o = '0;
    for (int s = 0; s < N_SLICES; s++) begin
      cnt_o = cnt_o + OUT_W'(slice_cnt[s]);
    end
  end

endmodule

// File: rtl/ldpc_syndrome_counter.sv
// Streaming frame-weight counter: beat popcount (stage P), accumulate (stage A), flagged result.
module ldpc_syndrome_counter
  import ldpc_pkg::*;
#(
  parameter int DATA_W  = LDPC_DATA_W,
  parameter int CHUNK_W = LDPC_CHUNK_W,
  parameter int LUT_W   = 8,
  parameter int COUNT_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CHUNK_W-1:0] in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  input  logic [COUNT_W-1:0] thr,
  output logic [COUNT_W-1:0] out_cnt,
  output logic               out_zero,
  output logic               out_below,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int BEATS  = DATA_W / CHUNK_W;
  localparam int PC_W   = clog2(CHUNK_W + 1);
  localparam int BEAT_W = (BEATS > 1) ? clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(BEATS - 1);

  state_e              state_q;
  logic                in_ready_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [COUNT_W-1:0]  thr_q;
  logic                err_q;

  logic                p_valid_q;
  logic                p_first_q;
  logic                p_last_q;
  logic [PC_W-1:0]     p_cnt_q;
  logic                a_last_q;
  logic [COUNT_W-1:0]  acc_q;
  logic [COUNT_W-1:0]  acc_d;

  logic                out_valid_q;
  logic [COUNT_W-1:0]  out_cnt_q;
  logic                out_zero_q;
  logic                out_below_q;
  logic                out_err_q;

  logic                accept;
  logic                first_beat;
  logic [BEAT_W-1:0]   beat_idx;
  logic                idx_final;
  logic                frame_end;
  logic                len_err;
  logic [PC_W-1:0]     chunk_cnt;

  popcount_chunk #(
    .CHUNK_W (CHUNK_W),
    .LUT_W   (LUT_W),
    .OUT_W   (PC_W)
  ) u_popcount (
    .data_i (in_data),
    .cnt_o  (chunk_cnt)
  );

  // A frame closes on in_last or on the last legal beat, whichever comes first;
  // disagreement between the two is a length error.
  always_comb begin
    accept     = in_valid && in_ready_q;
    first_beat = (state_q == IDLE);
    beat_idx   = first_beat ? '0 : beat_q;
    idx_final  = (beat_idx == LAST_IDX);
    frame_end  = in_last || idx_final;
    len_err    = (in_last != idx_final);
  end

  always_comb begin
    acc_d = p_first_q ? COUNT_W'(p_cnt_q) : acc_q + COUNT_W'(p_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid_q <= 1'b0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
      p_cnt_q   <= '0;
      a_last_q  <= 1'b0;
      acc_q     <= '0;
    end else begin
      p_valid_q <= accept;
      if (accept) begin
        p_cnt_q   <= chunk_cnt;
        p_first_q <= first_beat;
        p_last_q  <= frame_end;
      end
      a_last_q <= p_valid_q && p_last_q;
      if (p_valid_q) acc_q <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      beat_q      <= '0;
      thr_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_cnt_q   <= '0;
      out_zero_q  <= 1'b0;
      out_below_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            thr_q  <= thr;
            err_q  <= len_err;
            beat_q <= BEAT_W'(1);
            if (frame_end) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            beat_q <= beat_q + BEAT_W'(1);
            if (frame_end) begin
              err_q      <= len_err;
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // a_last_q marks the cycle in which acc_q already holds the final beat.
          if (a_last_q) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_cnt_q   <= acc_q;
            out_zero_q  <= (acc_q == '0);
            out_below_q <= (acc_q < thr_q);
            out_err_q   <= err_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_cnt   = out_cnt_q;
  assign out_zero  = out_zero_q;
  assign out_below = out_below_q;
  assign out_err   = out_err_q;

endmodule
